// File: rtl/wb_stage_if.sv
// Write-back stage port bundle: LS-stage payload and control in,
// register-file read data, write-back and retire status out.
interface wb_stage_if #(
    parameter int XLEN     = 64,
    parameter int INST_LEN = 32
);
    logic                ls_valid_i;
    logic [XLEN-1:0]     pc_i;
    logic [INST_LEN-1:0] instr_i;
    logic [XLEN-1:0]     alures_i;
    logic [XLEN-1:0]     ls_res_i;
    logic [XLEN-1:0]     csr_data_i;
    logic                stall_i;
    logic                flush_i;
    logic [4:0]          rs1_addr_i;
    logic [4:0]          rs2_addr_i;
    logic [XLEN-1:0]     rs1_data_o;
    logic [XLEN-1:0]     rs2_data_o;
    logic [XLEN-1:0]     wb_data_o;
    logic [4:0]          wb_rd_o;
    logic                wb_wen_o;
    logic                commit_o;
    logic [XLEN-1:0]     commit_pc_o;
    logic [63:0]         retire_cnt_o;

    modport master (
        output ls_valid_i, pc_i, instr_i, alures_i, ls_res_i,
        output csr_data_i, stall_i, flush_i, rs1_addr_i, rs2_addr_i,
        input  rs1_data_o, rs2_data_o, wb_data_o, wb_rd_o,
        input  wb_wen_o, commit_o, commit_pc_o, retire_cnt_o
    );

    modport slave (
        input  ls_valid_i, pc_i, instr_i, alures_i, ls_res_i,
        input  csr_data_i, stall_i, flush_i, rs1_addr_i, rs2_addr_i,
        output rs1_data_o, rs2_data_o, wb_data_o, wb_rd_o,
        output wb_wen_o, commit_o, commit_pc_o, retire_cnt_o
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: WB pipeline register, result select, register file
// with write bypass. Define WB_RETIRE_CNT_EN to build the retire counter.
module wb_stage #(
    parameter int XLEN     = 64,
    parameter int INST_LEN = 32
) (
    input  logic    clk,
    input  logic    rst_n,
    wb_stage_if.slave bus
);
    logic                valid_q;
    logic [XLEN-1:0]     pc_q;
    logic [INST_LEN-1:0] instr_q;
    logic [XLEN-1:0]     alures_q;
    logic [XLEN-1:0]     ls_res_q;
    logic [XLEN-1:0]     csr_data_q;
    logic [XLEN-1:0]     rf [32];

    logic [4:0]      opc;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic            is_load;
    logic            is_jump;
    logic            is_csr;
    logic            writes_rd;
    logic            wen;
    logic [XLEN-1:0] res;
    logic            unused;

    assign opc    = instr_q[6:2];
    assign funct3 = instr_q[14:12];
    assign rd     = instr_q[11:7];
    assign unused = ^instr_q[INST_LEN-1:15] ^ ^instr_q[1:0];

    // Capture on a live, unstalled, unflushed slot; payload holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            instr_q    <= '0;
            alures_q   <= '0;
            ls_res_q   <= '0;
            csr_data_q <= '0;
        end else if (bus.flush_i || bus.stall_i || !bus.ls_valid_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q    <= 1'b1;
            pc_q       <= bus.pc_i;
            instr_q    <= bus.instr_i;
            alures_q   <= bus.alures_i;
            ls_res_q   <= bus.ls_res_i;
            csr_data_q <= bus.csr_data_i;
        end
    end

    // Decode the opcode class of the WB-held instruction.
    always_comb begin
        is_load   = (opc == 5'b00000);
        is_jump   = (opc == 5'b11011) || (opc == 5'b11001);
        is_csr    = (opc == 5'b11100) && (funct3 != 3'd0);
        writes_rd = 1'b0;
        case (opc)
            5'b01100, 5'b00100, 5'b01110, 5'b00110,
            5'b01101, 5'b00101, 5'b00000, 5'b11011,
            5'b11001: writes_rd = 1'b1;
            5'b11100: writes_rd = (funct3 != 3'd0);
            default:  writes_rd = 1'b0;
        endcase
    end

    // Pick the write-back value; link address wraps naturally.
    always_comb begin
        res = alures_q;
        unique case (1'b1)
            is_load: res = ls_res_q;
            is_jump: res = pc_q + XLEN'(4);
            is_csr:  res = csr_data_q;
            default: res = alures_q;
        endcase
    end

    assign wen = valid_q && writes_rd && (rd != 5'd0);

    // Register array; x0 is never a write target since wen excludes rd 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wen) begin
            rf[rd] <= res;
        end
    end

    function automatic logic [XLEN-1:0] rd_port(input logic [4:0] a);
        if (a == 5'd0)
            return '0;
        else if (wen && (a == rd))
            return res;
        else
            return rf[a];
    endfunction

    assign bus.rs1_data_o  = rd_port(bus.rs1_addr_i);
    assign bus.rs2_data_o  = rd_port(bus.rs2_addr_i);
    assign bus.wb_data_o   = res;
    assign bus.wb_rd_o     = rd;
    assign bus.wb_wen_o    = wen;
    assign bus.commit_o    = valid_q;
    assign bus.commit_pc_o = pc_q;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] cnt_q;

    // Count each retiring instruction; wraps at 2^64.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (valid_q)
            cnt_q <= cnt_q + 64'd1;
    end

    assign bus.retire_cnt_o = cnt_q;
`else
    assign bus.retire_cnt_o = '0;
`endif
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter: XLEN, 64, datapath width.
REQ-002 Parameter: INST_LEN, 32, instruction width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: ls_valid_i  input  1  LS stage holds a live instruction this cycle.
REQ-006 Port: pc_i  input  XLEN  PC of the LS-stage instruction.
REQ-007 Port: instr_i  input  INST_LEN  LS-stage instruction.
REQ-008 Port: alures_i  input  XLEN  ALU result from LS stage.
REQ-009 Port: ls_res_i  input  XLEN  load data from LS stage.
REQ-010 Port: csr_data_i  input  XLEN  CSR read data from LS stage.
REQ-011 Port: stall_i  input  1  upstream hold; WB takes a bubble this edge.
REQ-012 Port: flush_i  input  1  trap or redirect; WB takes a bubble this edge.
REQ-013 Port: rs1_addr_i, rs2_addr_i  input  5 each  register-file read addresses.
REQ-014 Port: rs1_data_o, rs2_data_o  output  XLEN each  register-file read data.
REQ-015 Port: wb_data_o  output  XLEN  selected write-back value, driven to the LS store-data forwarding path.
REQ-016 Port: wb_rd_o  output  5  destination register held in WB.
REQ-017 Port: wb_wen_o  output  1  register write enable held in WB.
REQ-018 Port: commit_o  output  1  one-cycle pulse per retired instruction.
REQ-019 Port: commit_pc_o  output  XLEN  PC of the retiring instruction.
REQ-020 Port: retire_cnt_o  output  64  retired-instruction count.

Function
REQ-021 WB pipeline register: at each edge, if flush_i or stall_i or !ls_valid_i, then valid_q<=0; else valid_q<=1 and pc, instr, alures, ls_res, csr_data are captured.
REQ-022 flush_i has priority over stall_i; both together still yield a bubble.
REQ-023 Payload registers hold their contents when valid_q<=0; only valid_q gates side effects.
REQ-024 Result select on instr_q[6:2]: load 00000 -> ls_res_q; jal 11011 or jalr 11001 -> pc_q+4; system 11100 with funct3!=0 -> csr_data_q; otherwise alures_q.
REQ-025 pc_q+4 wraps modulo 2^XLEN.
REQ-026 Writes rd: opcodes 01100, 00100, 01110, 00110, 01101, 00101, 00000, 11011, 11001, and 11100 with funct3!=0.
REQ-027 Never writes rd: store, branch, ecall/ebreak/mret, and unknown opcodes.
REQ-028 wb_wen_o = valid_q & writes-rd & (rd!=0).
REQ-029 wb_rd_o = instr_q[11:7]; wb_data_o is the selected result, combinational from WB registers.
REQ-030 Register file: 32 x XLEN; written at the edge following capture when wb_wen_o=1; x0 is never written.
REQ-031 Read ports are combinational; address 0 returns 0.
REQ-032 Read bypass: if wb_wen_o and read address == wb_rd_o (nonzero), the port returns wb_data_o.
REQ-033 commit_o = valid_q; commit_pc_o = pc_q.
REQ-034 Latency: instruction captured at edge N; commit_o high in cycle N..N+1; regfile updated at edge N+1.
REQ-035 Back-to-back writes to the same rd: the later value wins; the bypass reflects the WB-held instruction only.

Reset
REQ-036 On rst_n low, asynchronously: valid_q=0, all payload registers 0, all 32 registers 0, retire counter 0.
REQ-037 Outputs during reset: commit_o=0, wb_wen_o=0, wb_data_o=0, rs*_data_o=0, retire_cnt_o=0.
REQ-038 Reset asserted mid-write cancels the pending regfile write.
REQ-039 The first capture occurs on the first rising edge after rst_n deasserts.

Configuration
REQ-040 WB_RETIRE_CNT_EN defined: a 64-bit counter increments at each edge where valid_q=1, wraps from 2^64-1 to 0, and drives retire_cnt_o.
REQ-041 WB_RETIRE_CNT_EN undefined: no counter flops are generated; retire_cnt_o is tied to 0.

Verification
REQ-042 addi x5 (alures=0x10) with ls_valid_i=1 -> next cycle: wb_wen_o=1, wb_rd_o=5, wb_data_o=0x10; rs1_addr=5 reads 0x10 via bypass; after the following edge, reads 0x10 from the array.
REQ-043 ld x7 with ls_res_i=0xDEADBEEF00000001 -> wb_data_o=0xDEADBEEF00000001; jal x1 at pc=0x80000000 -> wb_data_o=0x80000004.
REQ-044 addi x0, alures=0x55 -> wb_wen_o=0, commit_o=1; x0 reads 0.
REQ-045 sd, then beq, then csrrw x3 (csr_data=0x1800) -> only the csrrw writes x3=0x1800; commit_o pulses three times.
REQ-046 Valid addi with flush_i=1 (and separately stall_i=1) -> commit_o=0 and no write next cycle; rst_n pulsed low mid-stream -> all outputs 0 immediately.
REQ-047 With WB_RETIRE_CNT_EN, 5 valid instructions plus 2 bubbles -> retire_cnt_o=5; counter preset near 2^64-1 wraps to 0.
